// File: rtl/ttl_74259_sync_if.sv
// Bus bundle for the ttl_74259_sync addressable latch; the Auto/Count
// signals exist only when TTL_74259_AUTOINC_EN is defined.
interface ttl_74259_sync_if #(
  parameter int BLOCKS       = 2,
  parameter int WIDTH_OUT    = 4,
  parameter int WIDTH_SELECT = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1
);
  logic [BLOCKS-1:0]           enable_bar;
  logic [BLOCKS-1:0]           clear_bar;
  logic [WIDTH_SELECT-1:0]     select;
  logic [BLOCKS-1:0]           d;
  logic [BLOCKS*WIDTH_OUT-1:0] q;
`ifdef TTL_74259_AUTOINC_EN
  logic                        auto;
  logic [WIDTH_SELECT-1:0]     count;
`endif

  modport master (
    output enable_bar, clear_bar, select, d,
`ifdef TTL_74259_AUTOINC_EN
    output auto,
    input  count,
`endif
    input  q
  );

  modport slave (
    input  enable_bar, clear_bar, select, d,
`ifdef TTL_74259_AUTOINC_EN
    input  auto,
    output count,
`endif
    output q
  );
endinterface

// File: rtl/ttl_74259_sync.sv
// Clocked 74259-style dual addressable latch / demultiplexer with HOLD, LATCH,
// DEMUX and CLEAR modes per block. Optional address auto-increment: TTL_74259_AUTOINC_EN.
module ttl_74259_sync #(
  parameter int BLOCKS       = 2,
  parameter int WIDTH_OUT    = 4,
  parameter int WIDTH_SELECT = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1,
  parameter int DELAY_RISE   = 0,
  parameter int DELAY_FALL   = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  ttl_74259_sync_if.slave       bus_if
);
  localparam int NQ = BLOCKS * WIDTH_OUT;

  logic [NQ-1:0]           q_q;
  logic [NQ-1:0]           q_d;
  logic [WIDTH_SELECT-1:0] sel_eff;

`ifdef TTL_74259_AUTOINC_EN
  logic [WIDTH_SELECT-1:0] count_q;
  logic [WIDTH_SELECT-1:0] count_d;
  logic                    step;

  // Any block with Enable_bar low is writing (LATCH or DEMUX), so the address advances.
  assign step    = bus_if.auto & ~(&bus_if.enable_bar);
  assign sel_eff = bus_if.auto ? count_q : bus_if.select;
  assign count_d = !step ? count_q :
                   (count_q == WIDTH_SELECT'(WIDTH_OUT - 1)) ? '0 : count_q + 1'b1;
  assign bus_if.count = count_q;
`else
  assign sel_eff = bus_if.select;
`endif

  // An out-of-range select matches no bit: LATCH writes nothing, DEMUX clears the block.
  always_comb begin
    q_d = q_q;
    for (int b = 0; b < BLOCKS; b++) begin
      for (int j = 0; j < WIDTH_OUT; j++) begin
        case ({bus_if.clear_bar[b], bus_if.enable_bar[b]})
          2'b10: if (sel_eff == WIDTH_SELECT'(j)) q_d[b*WIDTH_OUT + j] = bus_if.d[b];
          2'b00: q_d[b*WIDTH_OUT + j] = (sel_eff == WIDTH_SELECT'(j)) ? bus_if.d[b] : 1'b0;
          2'b01: q_d[b*WIDTH_OUT + j] = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= '0;
`ifdef TTL_74259_AUTOINC_EN
      count_q <= '0;
`endif
    end else begin
      q_q <= q_d;
`ifdef TTL_74259_AUTOINC_EN
      count_q <= count_d;
`endif
    end
  end

  assign #(DELAY_RISE, DELAY_FALL) bus_if.q = q_q;
endmodule

// File: tb/tb_ttl_74259_sync.sv
// Self-checking bench for ttl_74259_sync: directed scenarios plus randomized
// traffic against a per-bit array model; covers TTL_74259_AUTOINC_EN when defined.
module tb_ttl_74259_sync;
  localparam int B  = 2;
`ifdef TTL_74259_AUTOINC_EN
  localparam int WO = 3;
`else
  localparam int WO = 4;
`endif
  localparam int WS = (WO > 1) ? $clog2(WO) : 1;
  localparam int N  = B * WO;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  int   mq [B][WO];
  int   mcount;

  ttl_74259_sync_if #(.BLOCKS(B), .WIDTH_OUT(WO), .WIDTH_SELECT(WS)) bus ();

  ttl_74259_sync #(.BLOCKS(B), .WIDTH_OUT(WO), .WIDTH_SELECT(WS)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_q();
    logic [N-1:0] v;
    v = '0;
    for (int b = 0; b < B; b++)
      for (int j = 0; j < WO; j++)
        v[b*WO + j] = (mq[b][j] != 0);
    return v;
  endfunction

  // Apply one set of inputs across a rising edge, then advance the model by the mode rules.
  task automatic applyStimulus(input logic r, input logic [B-1:0] en, input logic [B-1:0] clr,
                               input logic [WS-1:0] sel, input logic [B-1:0] dd, input logic au);
    int es;
    rst = r;
    bus.enable_bar = en;
    bus.clear_bar  = clr;
    bus.select     = sel;
    bus.d          = dd;
`ifdef TTL_74259_AUTOINC_EN
    bus.auto = au;
`endif
    @(posedge clk);
    #1;
    es = int'(sel);
`ifdef TTL_74259_AUTOINC_EN
    if (au) es = mcount;
`endif
    if (r) begin
      for (int b = 0; b < B; b++)
        for (int j = 0; j < WO; j++) mq[b][j] = 0;
      mcount = 0;
    end else begin
      for (int b = 0; b < B; b++) begin
        if (!clr[b]) for (int j = 0; j < WO; j++) mq[b][j] = 0;
        if (!en[b] && es < WO) mq[b][es] = int'(dd[b]);
      end
      if (au && en != {B{1'b1}}) mcount = (mcount + 1) % WO;
    end
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, '1, '1, '0, '0, 1'b0);
    applyStimulus(1'b1, '1, '1, '0, '0, 1'b0);
    total++;
    if (bus.q !== '0) begin
      bad++;
      $display("[TB] FAIL reset_q got=%h want=%h", bus.q, {N{1'b0}});
    end
`ifdef TTL_74259_AUTOINC_EN
    total++;
    if (bus.count !== '0) begin
      bad++;
      $display("[TB] FAIL reset_count got=%0d want=0", bus.count);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, '1, '1, WS'($urandom_range(0, (1 << WS) - 1)), B'($urandom), 1'b0);
      total++;
      if (bus.q !== '0) begin
        bad++;
        $display("[TB] FAIL hold_after_reset got=%h want=%h", bus.q, {N{1'b0}});
      end
    end
  endtask

`ifndef TTL_74259_AUTOINC_EN
  task automatic test_latch();
    applyStimulus(1'b0, 2'b10, 2'b11, 2'd2, 2'b01, 1'b0);
    total++;
    if (bus.q !== 8'h04) begin
      bad++;
      $display("[TB] FAIL latch_sel2 got=%h want=%h", bus.q, 8'h04);
    end
    applyStimulus(1'b0, 2'b10, 2'b11, 2'd0, 2'b01, 1'b0);
    total++;
    if (bus.q !== 8'h05) begin
      bad++;
      $display("[TB] FAIL latch_sel0 got=%h want=%h", bus.q, 8'h05);
    end
  endtask

  task automatic test_demux();
    for (int s = 0; s < 4; s++) applyStimulus(1'b0, 2'b01, 2'b11, WS'(s), 2'b10, 1'b0);
    total++;
    if (bus.q !== 8'hF5) begin
      bad++;
      $display("[TB] FAIL fill_block1 got=%h want=%h", bus.q, 8'hF5);
    end
    applyStimulus(1'b0, 2'b01, 2'b01, 2'd1, 2'b10, 1'b0);
    total++;
    if (bus.q !== 8'h25) begin
      bad++;
      $display("[TB] FAIL demux_d1 got=%h want=%h", bus.q, 8'h25);
    end
    applyStimulus(1'b0, 2'b01, 2'b01, 2'd1, 2'b00, 1'b0);
    total++;
    if (bus.q !== 8'h05) begin
      bad++;
      $display("[TB] FAIL demux_d0 got=%h want=%h", bus.q, 8'h05);
    end
  endtask

  task automatic test_mixed_modes();
    applyStimulus(1'b0, 2'b01, 2'b11, 2'd1, 2'b10, 1'b0);
    applyStimulus(1'b0, 2'b01, 2'b11, 2'd3, 2'b10, 1'b0);
    total++;
    if (bus.q !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL block1_1010 got=%h want=%h", bus.q, 8'hA5);
    end
    // Block0 LATCH (clr=1,en=0) and block1 CLEAR (clr=0,en=1) on one edge.
    applyStimulus(1'b0, 2'b10, 2'b01, 2'd3, 2'b01, 1'b0);
    total++;
    if (bus.q !== 8'h0D) begin
      bad++;
      $display("[TB] FAIL latch_plus_clear got=%h want=%h", bus.q, 8'h0D);
    end
  endtask

  task automatic test_reset_priority();
    applyStimulus(1'b0, 2'b10, 2'b11, 2'd1, 2'b01, 1'b0);
    total++;
    if (bus.q[3:0] !== 4'hF) begin
      bad++;
      $display("[TB] FAIL fill_block0 got=%h want=%h", bus.q[3:0], 4'hF);
    end
    applyStimulus(1'b1, 2'b00, 2'b11, 2'd2, 2'b11, 1'b0);
    total++;
    if (bus.q !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_over_latch got=%h want=%h", bus.q, 8'h00);
    end
    applyStimulus(1'b0, 2'b10, 2'b11, 2'd0, 2'b01, 1'b0);
    total++;
    if (bus.q !== 8'h01) begin
      bad++;
      $display("[TB] FAIL resume_after_reset got=%h want=%h", bus.q, 8'h01);
    end
  endtask
`else
  task automatic test_autoinc();
    int seq [4] = '{0, 1, 2, 0};
    for (int k = 0; k < 4; k++) begin
      total++;
      if (int'(bus.count) !== seq[k]) begin
        bad++;
        $display("[TB] FAIL count_step%0d got=%0d want=%0d", k, bus.count, seq[k]);
      end
      applyStimulus(1'b0, 2'b10, 2'b11, '0, 2'b01, 1'b1);
    end
    total++;
    if (bus.q[2:0] !== 3'b111) begin
      bad++;
      $display("[TB] FAIL auto_fill got=%b want=111", bus.q[2:0]);
    end
    total++;
    if (int'(bus.count) !== 1) begin
      bad++;
      $display("[TB] FAIL count_wrap got=%0d want=1", bus.count);
    end
    applyStimulus(1'b0, 2'b10, 2'b10, 2'd3, 2'b01, 1'b0);
    total++;
    if (bus.q[2:0] !== 3'b000) begin
      bad++;
      $display("[TB] FAIL demux_out_of_range got=%b want=000", bus.q[2:0]);
    end
    total++;
    if (int'(bus.count) !== 1) begin
      bad++;
      $display("[TB] FAIL count_hold got=%0d want=1", bus.count);
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] want;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(($urandom_range(0, 19) == 0), B'($urandom), B'($urandom),
                    WS'($urandom_range(0, (1 << WS) - 1)), B'($urandom), 1'($urandom));
      want = model_q();
      total++;
      if (bus.q !== want) begin
        bad++;
        $display("[TB] FAIL random_q[%0d] got=%h want=%h", k, bus.q, want);
      end
`ifdef TTL_74259_AUTOINC_EN
      total++;
      if (int'(bus.count) !== mcount) begin
        bad++;
        $display("[TB] FAIL random_count[%0d] got=%0d want=%0d", k, bus.count, mcount);
      end
`endif
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mcount = 0;
    rst = 1'b1;
    bus.enable_bar = '1;
    bus.clear_bar  = '1;
    bus.select     = '0;
    bus.d          = '0;
`ifdef TTL_74259_AUTOINC_EN
    bus.auto = 1'b0;
`endif
    test_reset();
`ifndef TTL_74259_AUTOINC_EN
    test_latch();
    test_demux();
    test_mixed_modes();
    test_reset_priority();
`else
    test_autoinc();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ttl_74259_sync.md
Name: ttl_74259_sync

Overview:
- Clocked dual addressable latch / 1-to-N demultiplexer, modelled on the 74259; it is the write-side counterpart of the 4-input selector parts.
- Each block routes one data bit to the output bit chosen by a shared Select bus and holds it in a register.
- Used wherever the CPU fans a single serial or control bit out into individually addressed flag or control lines.
- Four modes per block (hold, addressable latch, demux, clear), all registered on one clock.

Parameters:
- BLOCKS, 2, number of independent latch blocks.
- WIDTH_OUT, 4, outputs per block; need not be a power of two.
- WIDTH_SELECT, $clog2(WIDTH_OUT), width of the Select bus.
- DELAY_RISE, 0, rise delay applied to Q.
- DELAY_FALL, 0, fall delay applied to Q.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Enable_bar  input  BLOCKS  per-block enable, active low.
- Clear_bar  input  BLOCKS  per-block clear/mode input, active low.
- Select  input  WIDTH_SELECT  output address, shared by all blocks.
- D  input  BLOCKS  data bit per block.
- Q  output  BLOCKS*WIDTH_OUT  registered outputs; block i occupies Q[i*WIDTH_OUT +: WIDTH_OUT].

Behaviour:
- All state changes on the rising edge of Clk; Q reflects the new value one edge after inputs are sampled. No combinational path from inputs to Q.
- Reset=1 at an edge: all Q bits go to 0. Reset has priority over every mode, including reset asserted mid-sequence; the next edge with Reset=0 resumes normal operation.
- Reset value of every output is 0. Q is undefined only before the first reset edge.
- Per-block mode, decoded from {Clear_bar[i], Enable_bar[i]}:
  - 1,1 HOLD: block i outputs unchanged.
  - 1,0 LATCH: block i bit Select becomes D[i]; the other bits of block i are unchanged.
  - 0,0 DEMUX: block i bit Select becomes D[i]; all other bits of block i become 0.
  - 0,1 CLEAR: all bits of block i become 0.
- Blocks are fully independent. Different modes in different blocks on the same edge are legal and each applies its own rule.
- Select >= WIDTH_OUT (non-power-of-two WIDTH_OUT):
  - LATCH: no bit written (behaves as HOLD).
  - DEMUX: all bits of the block become 0.
- Select and D changing every cycle is legal; only values present at the edge matter.
- The output delay #(DELAY_RISE, DELAY_FALL) is applied on the continuous assign from the internal register to Q.

Optional Feature:
- Macro: TTL_74259_AUTOINC_EN.
- Defined:
  - Adds input Auto (1 bit) and output Count (WIDTH_SELECT bits).
  - Count is an internal address register, reset to 0 by Reset.
  - When Auto=1, the effective select is Count instead of Select.
  - Count increments by 1 after every edge on which Auto=1 and at least one block is in LATCH or DEMUX mode.
  - Count wraps from WIDTH_OUT-1 to 0.
  - Count holds when Auto=0, or when all blocks are in HOLD or CLEAR.
  - Reset on the same edge as an increment condition: Count=0, Q=0.
- Undefined: Auto and Count ports do not exist; effective select is always Select; behaviour is otherwise identical.

Test Plan:
- Reset=1 for 2 edges, then all blocks HOLD -> Q=8'h00 and stays 8'h00.
- Block0 LATCH, Select=2, D[0]=1; then Select=0, D[0]=1 -> Q[3:0]=4'b0100, then 4'b0101; Q[7:4] unchanged at 0.
- Block1 holds 4'b1111; apply DEMUX with Select=1, D[1]=1 -> Q[7:4]=4'b0010. Same with D[1]=0 -> 4'b0000.
- Block0 LATCH writes 1 to Select=3 while block1 CLEAR on the same edge, block1 previously 4'b1010 -> Q=8'b0000_1xxx with bit3=1; block1 bits all 0.
- Fill block0 to 4'b1111, then assert Reset and LATCH on the same edge -> Q=8'h00; next edge (LATCH, Select=0, D=1) -> Q[3:0]=4'b0001.
- AUTOINC_EN build, WIDTH_OUT=3:
  - Auto=1, block0 LATCH, D[0]=1 for 4 edges -> Count sequence 0,1,2,0; Q[2:0]=3'b111.
  - Then Select=3 (out of range), Auto=0, DEMUX -> Q[2:0]=3'b000, Count holds at 1.
